// File: rtl/ahb_pkg.sv
// Shared encodings and helpers for the AHB-Lite slave subsystem.
// Holds HTRANS/HSIZE/HRESP encodings, region base addresses, the data-phase
// slave-select enum, the error-response FSM state type and the byte-lane and
// access-legality helpers used by the memory slaves.
package ahb_pkg;

  localparam logic [1:0] HtransIdle   = 2'd0;
  localparam logic [1:0] HtransBusy   = 2'd1;
  localparam logic [1:0] HtransNonseq = 2'd2;
  localparam logic [1:0] HtransSeq    = 2'd3;

  localparam logic [2:0] HsizeByte = 3'd0;
  localparam logic [2:0] HsizeHalf = 3'd1;
  localparam logic [2:0] HsizeWord = 3'd2;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  // Each region is 1 KB, so HADDR[31:10] identifies it.
  localparam logic [31:0] Mem0Base = 32'h0000_0000;
  localparam logic [31:0] Mem1Base = 32'h0000_0400;

  typedef enum logic [1:0] {
    SelNone,
    SelMem0,
    SelMem1,
    SelDefault
  } slave_sel_e;

  typedef enum logic [1:0] {
    StIdle,
    StErr1,
    StErr2
  } err_state_e;

  // Oversized or misaligned accesses are rejected.
  function automatic logic access_bad(input logic [2:0] size, input logic [1:0] lsb);
    return (size > HsizeWord) ||
           ((size == HsizeHalf) && lsb[0]) ||
           ((size == HsizeWord) && (lsb != 2'b00));
  endfunction

  // Little-endian byte-lane enables for a legal access.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] mask;
    case (size)
      HsizeByte: mask = 4'b0001 << lsb;
      HsizeHalf: mask = lsb[1] ? 4'b1100 : 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_mem_slave.sv
// Zero-wait-state 256 x 32 SRAM slave with a two-cycle ERROR response.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   sel           : region decode for the current address phase
//   trans_active  : HTRANS is NONSEQ or SEQ
//   hready        : bus HREADY (address-phase sample enable)
//   haddr         : low 10 address bits, hsize, hwrite : address-phase controls
//   hwdata        : write data in the data phase
//   hrdata        : read data (zero unless an OKAY read is in its data phase)
//   hreadyout     : low only in the first ERROR cycle
//   hresp         : ERROR during both ERROR cycles
module ahb_mem_slave
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        trans_active,
  input  logic        hready,
  input  logic [9:0]  haddr,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  // Contents are deliberately not reset.
  logic [31:0] mem [256];

  logic       ok_q;
  logic       write_q;
  logic [7:0] idx_q;
  logic [3:0] mask_q;
  err_state_e state_q, state_d;

  logic req;
  logic bad;

  assign req = hready & sel & trans_active;
  assign bad = access_bad(hsize, haddr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q    <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
      mask_q  <= '0;
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
      if (hready) begin
        ok_q    <= req & ~bad;
        write_q <= hwrite;
        idx_q   <= haddr[9:2];
        mask_q  <= lane_mask(hsize, haddr[1:0]);
      end
    end
  end

  // ok_q is cleared asynchronously, so a write caught by reset never commits.
  always_ff @(posedge clk) begin
    if (ok_q && write_q && hready) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) begin
          mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StErr1:  state_d = StErr2;
      // StErr2 always has hready high, so the next address is sampled there.
      default: if (hready) state_d = (req && bad) ? StErr1 : StIdle;
    endcase
  end

  assign hreadyout = (state_q != StErr1);
  assign hresp     = (state_q != StIdle) ? HrespError : HrespOkay;
  assign hrdata    = (ok_q && !write_q) ? mem[idx_q] : 32'h0;

endmodule

// File: rtl/ahb_top.sv
// AHB-Lite slave subsystem: address decoder, two 1 KB memory slaves, a default
// error slave and the data-phase response multiplexor.
// Ports: HCLK, HRESETn (async active-low); address-phase inputs HADDR, HSIZE,
// HBURST, HTRANS, HWRITE, HMASTLOCK, HPROT; data-phase input HWDATA;
// outputs HREADY (also the internal slaves' HREADY), HRDATA, HRESP.
module ahb_top
  import ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  output logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  // Bursts carry per-beat addresses; lock and protection are not modelled.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT, HTRANS[0]};

  logic       trans_active;
  slave_sel_e addr_sel;
  slave_sel_e sel_q;
  err_state_e def_q, def_d;

  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1;
  logic        resp0, resp1;

  assign trans_active = HTRANS[1];

  always_comb begin
    addr_sel = SelDefault;
    if (HADDR[31:10] == Mem0Base[31:10]) begin
      addr_sel = SelMem0;
    end else if (HADDR[31:10] == Mem1Base[31:10]) begin
      addr_sel = SelMem1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q <= SelNone;
      def_q <= StIdle;
    end else begin
      def_q <= def_d;
      if (HREADY) begin
        sel_q <= trans_active ? addr_sel : SelNone;
      end
    end
  end

  // Default slave: every real access to it gets the two-cycle ERROR.
  always_comb begin
    def_d = def_q;
    case (def_q)
      StErr1:  def_d = StErr2;
      default: begin
        if (HREADY) def_d = (trans_active && addr_sel == SelDefault) ? StErr1 : StIdle;
      end
    endcase
  end

  ahb_mem_slave u_mem0 (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .sel          (addr_sel == SelMem0),
    .trans_active (trans_active),
    .hready       (HREADY),
    .haddr        (HADDR[9:0]),
    .hsize        (HSIZE),
    .hwrite       (HWRITE),
    .hwdata       (HWDATA),
    .hrdata       (rdata0),
    .hreadyout    (ready0),
    .hresp        (resp0)
  );

  ahb_mem_slave u_mem1 (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .sel          (addr_sel == SelMem1),
    .trans_active (trans_active),
    .hready       (HREADY),
    .haddr        (HADDR[9:0]),
    .hsize        (HSIZE),
    .hwrite       (HWRITE),
    .hwdata       (HWDATA),
    .hrdata       (rdata1),
    .hreadyout    (ready1),
    .hresp        (resp1)
  );

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HrespOkay;
    HRDATA = 32'h0;
    case (sel_q)
      SelMem0: begin
        HREADY = ready0;
        HRESP  = resp0;
        HRDATA = rdata0;
      end
      SelMem1: begin
        HREADY = ready1;
        HRESP  = resp1;
        HRDATA = rdata1;
      end
      SelDefault: begin
        HREADY = (def_q != StErr1);
        HRESP  = (def_q != StIdle) ? HrespError : HrespOkay;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_top.sv
// Randomized self-checking bench for ahb_top, checked against a byte-array
// reference model of the address map, lane rules and error rules.
module tb_ahb_top;

  localparam logic [1:0] TrIdle   = 2'd0;
  localparam logic [1:0] TrBusy   = 2'd1;
  localparam logic [1:0] TrNonseq = 2'd2;
  localparam logic [1:0] TrSeq    = 2'd3;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  ahb_top dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HMASTLOCK (HMASTLOCK),
    .HPROT     (HPROT),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 2 KB of mapped memory as bytes.
  logic [7:0] ref_mem [2048];

  // Beat whose data phase is outstanding.
  logic        p_act = 1'b0;
  logic        p_wr = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_wdata = '0;
  logic [2:0]  p_size = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [31:0] addr, input logic [2:0] size);
    if (size > 3'd2) return 1'b1;
    if ((addr % (32'd1 << size)) != 0) return 1'b1;
    return addr >= 32'd2048;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int b;
    b = int'(addr) & ~3;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata);
    for (int i = 0; i < (1 << size); i++) begin
      ref_mem[int'(addr) + i] = wdata[8*((int'(addr) + i) % 4) +: 8];
    end
  endtask

  // Completes the outstanding data phase; the next address phase stays on the bus.
  task automatic data_phase();
    @(negedge HCLK);
    if (!p_act) begin
      check_eq("idle_hready", 32'(HREADY), 32'd1);
      check_eq("idle_hresp", 32'(HRESP), 32'd0);
      check_eq("idle_hrdata", HRDATA, 32'h0);
    end else if (ref_err(p_addr, p_size)) begin
      check_eq("err1_hready", 32'(HREADY), 32'd0);
      check_eq("err1_hresp", 32'(HRESP), 32'd1);
      @(posedge HCLK);
      #1;
      @(negedge HCLK);
      check_eq("err2_hready", 32'(HREADY), 32'd1);
      check_eq("err2_hresp", 32'(HRESP), 32'd1);
      if (!p_wr) check_eq("err_hrdata", HRDATA, 32'h0);
    end else begin
      check_eq("ok_hready", 32'(HREADY), 32'd1);
      check_eq("ok_hresp", 32'(HRESP), 32'd0);
      if (p_wr) ref_write(p_addr, p_size, p_wdata);
      else check_eq("rd_data", HRDATA, ref_word(p_addr));
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic beat(input logic [1:0] trans, input logic [31:0] addr, input logic [2:0] size,
                      input logic wr, input logic [31:0] wdata);
    HTRANS = trans;
    HADDR  = addr;
    HSIZE  = size;
    HWRITE = wr;
    HWDATA = p_wdata;
    data_phase();
    p_act   = trans[1];
    p_addr  = addr;
    p_size  = size;
    p_wr    = wr;
    p_wdata = wdata;
  endtask

  task automatic flush();
    beat(TrIdle, 32'h0, 3'd0, 1'b0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_hready"}, 32'(HREADY), 32'd1);
    check_eq({tag, "_hresp"}, 32'(HRESP), 32'd0);
    check_eq({tag, "_hrdata"}, HRDATA, 32'h0);
  endtask

  initial begin
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] ad;

    HRESETn = 1'b0;
    HADDR = '0; HWDATA = '0; HSIZE = '0; HBURST = '0; HTRANS = TrIdle;
    HWRITE = 1'b0; HMASTLOCK = 1'b0; HPROT = 4'h3;

    // Reset held for one cycle.
    @(posedge HCLK);
    #1;
    check_reset_outputs("reset");
    HRESETn = 1'b1;

    // Give every word a known value (back-to-back word writes).
    for (int w = 0; w < 512; w++) beat(TrNonseq, 32'(w * 4), 3'd2, 1'b1, $urandom);
    flush();

    // Word write then back-to-back read.
    beat(TrNonseq, 32'h10, 3'd2, 1'b1, 32'hDEAD_BEEF);
    beat(TrNonseq, 32'h10, 3'd2, 1'b0, 32'h0);
    flush();

    // Partial writes into memory slave 1.
    beat(TrNonseq, 32'h404, 3'd2, 1'b1, 32'h1122_3344);
    beat(TrNonseq, 32'h405, 3'd0, 1'b1, 32'h0000_AA00);
    beat(TrNonseq, 32'h404, 3'd2, 1'b0, 32'h0);
    beat(TrNonseq, 32'h406, 3'd1, 1'b1, 32'hBEEF_0000);
    beat(TrNonseq, 32'h404, 3'd2, 1'b0, 32'h0);
    flush();
    check_eq("partial_word", ref_word(32'h404), 32'hBEEF_AA44);

    // Unmapped read, misaligned and oversized writes, then read of 0x0.
    beat(TrNonseq, 32'h1000, 3'd2, 1'b0, 32'h0);
    beat(TrNonseq, 32'h2, 3'd2, 1'b1, 32'hFFFF_FFFF);
    beat(TrNonseq, 32'h0, 3'd3, 1'b1, 32'hFFFF_FFFF);
    beat(TrNonseq, 32'h0, 3'd2, 1'b0, 32'h0);
    flush();

    // INCR4 with a BUSY cycle, then read back.
    HBURST = 3'd3;
    beat(TrNonseq, 32'h20, 3'd2, 1'b1, 32'd1);
    beat(TrSeq, 32'h24, 3'd2, 1'b1, 32'd2);
    beat(TrBusy, 32'h28, 3'd2, 1'b1, 32'd0);
    beat(TrSeq, 32'h28, 3'd2, 1'b1, 32'd3);
    beat(TrSeq, 32'h2C, 3'd2, 1'b1, 32'd4);
    beat(TrNonseq, 32'h20, 3'd2, 1'b0, 32'h0);
    beat(TrSeq, 32'h24, 3'd2, 1'b0, 32'h0);
    beat(TrSeq, 32'h28, 3'd2, 1'b0, 32'h0);
    beat(TrSeq, 32'h2C, 3'd2, 1'b0, 32'h0);
    flush();
    HBURST = 3'd0;
    check_eq("burst_word3", ref_word(32'h2C), 32'd4);

    // Reset during a write data phase: memory must keep its old value.
    beat(TrNonseq, 32'h30, 3'd2, 1'b1, 32'h5A5A_5A5A);
    HTRANS = TrIdle;
    HWDATA = p_wdata;
    #2;
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("rst_wr");
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    p_act = 1'b0;
    beat(TrNonseq, 32'h30, 3'd2, 1'b0, 32'h0);
    flush();

    // Reset during the first ERROR cycle releases HREADY at once.
    beat(TrNonseq, 32'h1000, 3'd2, 1'b0, 32'h0);
    HTRANS = TrIdle;
    #2;
    check_eq("rst_err_pre_hready", 32'(HREADY), 32'd0);
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("rst_err");
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    p_act = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 19))
        0, 1:    tr = TrIdle;
        2:       tr = TrBusy;
        default: tr = $urandom_range(0, 1) ? TrSeq : TrNonseq;
      endcase
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) ad = $urandom | 32'h0000_0800;
      else ad = 32'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) != 0 && sz <= 3'd2) ad = ad & ~((32'd1 << sz) - 32'd1);
      beat(tr, ad, sz, 1'($urandom_range(0, 1)), $urandom);
    end
    flush();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time bound so a stuck bus cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
